// File: rtl/freelist_pkg.sv
// Shared defines for the physical-register freelist: register counts,
// derived widths and a small population-count helper.
package freelist_pkg;

  localparam int unsigned PREG_NUM = 64;
  localparam int unsigned ARCH_NUM = 32;
  localparam int unsigned PREG_W   = $clog2(PREG_NUM);
  localparam int unsigned DEPTH    = PREG_NUM - ARCH_NUM;
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned PTR_W    = IDX_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Number of asserted bits among two single-bit strobes.
  function automatic logic [1:0] cnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/freelist_ptr_adv.sv
// Freelist pointer advance: adds 0, 1 or 2 to a wrap-bit pointer.
// The pointer is one bit wider than the array index, so plain modular
// addition toggles the wrap bit when the index crosses DEPTH-1 -> 0.
module freelist_ptr_adv
  import freelist_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic [W-1:0] ptr,
  input  logic [1:0]   inc,
  output logic [W-1:0] ptr_nxt_c
);

  // Natural wrap modulo 2*DEPTH.
  assign ptr_nxt_c = ptr + W'(inc);

endmodule

// File: rtl/freelist.sv
// Physical-register freelist for a two-wide rename stage.
// Circular flop array with a speculative head (rename), an architectural
// head (commit) and a tail (register release). A flush rewinds the
// speculative head to the architectural head.
// Optional feature macro: FREELIST_PERF_CNT_EN adds a 64-bit saturating
// stall counter output, freelist_stall_cnt.
module freelist
  import freelist_pkg::*;
#(
  parameter int unsigned PREG_NUM = freelist_pkg::PREG_NUM,
  parameter int unsigned ARCH_NUM = freelist_pkg::ARCH_NUM,
  parameter int unsigned DEPTH    = PREG_NUM - ARCH_NUM
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        instr0_freelist_req,
  input  logic                        instr1_freelist_req,
  output logic [$clog2(PREG_NUM)-1:0] instr0_freelist_resp,
  output logic [$clog2(PREG_NUM)-1:0] instr1_freelist_resp,
  output logic                        freelist_stall,
  input  logic                        commit0_free_valid,
  input  logic                        commit1_free_valid,
  input  logic [$clog2(PREG_NUM)-1:0] commit0_free_prd,
  input  logic [$clog2(PREG_NUM)-1:0] commit1_free_prd,
  input  logic                        commit0_alloc_valid,
  input  logic                        commit1_alloc_valid,
  input  logic                        flush_valid
`ifdef FREELIST_PERF_CNT_EN
  ,
  output logic [63:0]                 freelist_stall_cnt
`endif
);

  localparam int unsigned RW = $clog2(PREG_NUM);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [RW-1:0] mem [DEPTH];

  logic [PW-1:0] spec_head;
  logic [PW-1:0] arch_head;
  logic [PW-1:0] tail;
  logic [PW-1:0] spec_head_nxt;
  logic [PW-1:0] arch_head_nxt;
  logic [PW-1:0] tail_nxt;
  logic [PW-1:0] count;

  logic [1:0]    alloc_n;
  logic [1:0]    free_n;
  logic [1:0]    commit_n;

  logic [IW-1:0] spec_idx;
  logic [IW-1:0] spec_idx1;
  logic [IW-1:0] tail_idx;
  logic [IW-1:0] free1_idx;

  // Occupancy and stall come straight from registered pointers.
  assign count          = tail - spec_head;
  assign freelist_stall = (count < PW'(2));

  // Allocation responses read the array at the speculative head.
  assign spec_idx             = spec_head[IW-1:0];
  assign spec_idx1            = spec_idx + IW'(1);
  assign instr0_freelist_resp = mem[spec_idx];
  assign instr1_freelist_resp = instr0_freelist_req ? mem[spec_idx1] : mem[spec_idx];

  // Per-cycle advance amounts; a stalled cycle accepts nothing.
  assign alloc_n  = freelist_stall ? 2'd0 : cnt2(instr0_freelist_req, instr1_freelist_req);
  assign free_n   = cnt2(commit0_free_valid, commit1_free_valid);
  assign commit_n = cnt2(commit0_alloc_valid, commit1_alloc_valid);

  // Port 1 packs behind port 0 only when port 0 also frees.
  assign tail_idx  = tail[IW-1:0];
  assign free1_idx = commit0_free_valid ? (tail_idx + IW'(1)) : tail_idx;

  freelist_ptr_adv #(.W(PW)) u_spec_adv (
    .ptr       (spec_head),
    .inc       (alloc_n),
    .ptr_nxt_c (spec_head_nxt)
  );

  freelist_ptr_adv #(.W(PW)) u_arch_adv (
    .ptr       (arch_head),
    .inc       (commit_n),
    .ptr_nxt_c (arch_head_nxt)
  );

  freelist_ptr_adv #(.W(PW)) u_tail_adv (
    .ptr       (tail),
    .inc       (free_n),
    .ptr_nxt_c (tail_nxt)
  );

  // Pointer and array update; reset refills with the unmapped pregs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_head <= '0;
      arch_head <= '0;
      tail      <= PW'(DEPTH);
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RW'(ARCH_NUM + 32'(i));
      end
    end else begin
      arch_head <= arch_head_nxt;
      tail      <= tail_nxt;
      spec_head <= flush_valid ? arch_head_nxt : spec_head_nxt;
      if (commit0_free_valid) begin
        mem[tail_idx] <= commit0_free_prd;
      end
      if (commit1_free_valid) begin
        mem[free1_idx] <= commit1_free_prd;
      end
    end
  end

`ifdef FREELIST_PERF_CNT_EN
  // Counts cycles where rename wanted a register but was held off.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      freelist_stall_cnt <= '0;
    end else if (freelist_stall && (instr0_freelist_req || instr1_freelist_req)
                 && (freelist_stall_cnt != '1)) begin
      freelist_stall_cnt <= freelist_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: directed vector table, hand-written
// corner sequences and a randomized run against an integer-pointer model.
module tb_freelist;

  localparam int W     = 6;
  localparam int DEPTH = 32;
  localparam int ARCH  = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] resp0, resp1;
  logic         stall;
  logic         f0, f1;
  logic [W-1:0] p0, p1;
  logic         a0, a1;
  logic         fl;
`ifdef FREELIST_PERF_CNT_EN
  logic [63:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freelist dut (
    .clock                (clk),
    .reset                (rst),
    .instr0_freelist_req  (req0),
    .instr1_freelist_req  (req1),
    .instr0_freelist_resp (resp0),
    .instr1_freelist_resp (resp1),
    .freelist_stall       (stall),
    .commit0_free_valid   (f0),
    .commit1_free_valid   (f1),
    .commit0_free_prd     (p0),
    .commit1_free_prd     (p1),
    .commit0_alloc_valid  (a0),
    .commit1_alloc_valid  (a1),
    .flush_valid          (fl)
`ifdef FREELIST_PERF_CNT_EN
    ,
    .freelist_stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic         r0;
    logic         r1;
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         c0;
    logic         c1;
    logic         flush;
    int           e0;
    int           e1;
    logic         es;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int e0, input int e1, input logic es);
    chk({tag, "_resp0"}, 64'(resp0), 64'(e0));
    chk({tag, "_resp1"}, 64'(resp1), 64'(e1));
    chk({tag, "_stall"}, 64'(stall), 64'(es));
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle by +1.
  task automatic drive(input logic r0, input logic r1,
                       input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1,
                       input logic c0, input logic c1, input logic flush);
    @(negedge clk);
    req0 = r0; req1 = r1;
    f0 = v0; p0 = d0; f1 = v1; p1 = d1;
    a0 = c0; a1 = c1; fl = flush;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; f0 = 1'b0; f1 = 1'b0;
    p0 = '0; p1 = '0; a0 = 1'b0; a1 = 1'b0; fl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state: unbounded integer pointers, array indexed mod DEPTH.
  int m_mem [DEPTH];
  int m_sh, m_ah, m_tl;

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; f0 = 1'b0; f1 = 1'b0;
    p0 = '0; p1 = '0; a0 = 1'b0; a1 = 1'b0; fl = 1'b0;

    //          r0    r1    v0    d0     v1    d1     c0    c1    fl    e0  e1  es
    vecs[0] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 32, 33, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 34, 34, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 34, 34, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 35, 35, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 35, 35, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 34, 34, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 34, 35, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 35, 35, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 6'd7,  1'b1, 6'd9,  1'b0, 1'b0, 1'b0, 35, 35, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 35, 36, 1'b0};

    // Reset state.
    do_reset();
    #1;
    check_out("reset", ARCH, ARCH, 1'b0);
`ifdef FREELIST_PERF_CNT_EN
    chk("reset_cnt", stall_cnt, 64'd0);
`endif

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1,
            vecs[i].c0, vecs[i].c1, vecs[i].flush);
      check_out($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].es);
    end

    // Drain to one free entry, stall, then a single free clears the stall.
    do_reset();
    repeat (15) drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle();
    check_out("drain", 63, 63, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      check_out($sformatf("stalled%0d", k), 63, 32, 1'b1);
    end
`ifdef FREELIST_PERF_CNT_EN
    idle();
    chk("stall_cnt", stall_cnt, 64'd3);
`endif
    drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_out("free5_pre", 63, 63, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_out("free5_post", 63, 5, 1'b0);

    // Alloc and free together while full; freed pregs reappear in order.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 6'd7, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
    check_out("full_mix", 32, 33, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      int e;
      e = (k < 30) ? (34 + k) : ((k == 30) ? 7 : 9);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("order%0d_resp0", k), 64'(resp0), 64'(e));
      chk($sformatf("order%0d_stall", k), 64'(stall), 64'(k >= 31));
    end

    // Reset mid-operation takes effect immediately and drops a pending free.
    do_reset();
    repeat (3) drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; f0 = 1'b1; p0 = 6'd3;
    #1;
    check_out("midreset", ARCH, ARCH, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    f0 = 1'b0;
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_out("after_midreset", 32, 33, 1'b0);

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = ARCH + i;
    m_sh = 0; m_ah = 0; m_tl = DEPTH;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r0, r1, v0, v1, c0, c1, flush;
      logic [W-1:0] d0, d1;
      int cnt, avail, room, ah_new, n, e0, e1;
      logic es;
      r0 = 1'($urandom % 2);
      r1 = 1'($urandom % 2);
      avail = m_sh - m_ah;
      c0 = (avail >= 1) && ($urandom % 2 == 0);
      c1 = (avail >= (c0 ? 2 : 1)) && ($urandom % 2 == 0);
      ah_new = m_ah + int'(c0) + int'(c1);
      room = DEPTH - (m_tl - ah_new);
      v0 = (room >= 1) && ($urandom % 2 == 0);
      v1 = (room >= (v0 ? 2 : 1)) && ($urandom % 2 == 0);
      d0 = W'($urandom % 64);
      d1 = W'($urandom % 64);
      flush = ($urandom % 16 == 0);

      cnt = m_tl - m_sh;
      es  = (cnt < 2);
      e0  = m_mem[m_sh % DEPTH];
      e1  = r0 ? m_mem[(m_sh + 1) % DEPTH] : e0;

      drive(r0, r1, v0, d0, v1, d1, c0, c1, flush);
      check_out($sformatf("rnd%0d", cyc), e0, e1, es);

      n = es ? 0 : (int'(r0) + int'(r1));
      if (v0) m_mem[m_tl % DEPTH] = int'(d0);
      if (v1) m_mem[(m_tl + int'(v0)) % DEPTH] = int'(d1);
      m_tl = m_tl + int'(v0) + int'(v1);
      m_ah = ah_new;
      m_sh = flush ? m_ah : (m_sh + n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
